// File: rtl/sys_bridge_n.sv
// CPU-to-peripheral bridge: word-address decode, read-data mux and a small
// interrupt controller with per-line level/edge mode, mask and pending state.
module sys_bridge_n #(
  parameter int          N_DEV      = 4,
  parameter logic [31:0] DEV_BASE   = 32'h0000_7f00,
  parameter logic [31:0] DEV_STRIDE = 32'h0000_0010,
  parameter logic [31:0] DEV_SPAN   = 32'h0000_000c,
  parameter logic [31:0] IC_BASE    = 32'h0000_7f80,
  parameter int          N_IRQ      = 4,
  parameter int          HWINT_W    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pr_a,
  input  logic                 pr_we,
  input  logic [31:0]          pr_wd,
  output logic [31:0]          pr_rd,
  output logic                 addr_err,
  output logic [31:0]          dev_addr,
  output logic [31:0]          dev_wd,
  output logic [N_DEV-1:0]     dev_we,
  input  logic [32*N_DEV-1:0]  dev_rd,
  input  logic [N_IRQ-1:0]     irq,
  input  logic                 ext_int,
  output logic [HWINT_W-1:0]   hwint
);

  logic [31:0]      ra_s;
  logic [31:0]      ic_off_s;
  logic [N_DEV-1:0] sel_s;
  logic             sel_ic_s;
  logic             wr_mask_s;
  logic             wr_pend_s;
  logic             wr_mode_s;

  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] mode_q, mode_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] irq_q;

  assign ra_s     = {pr_a[31:2], 2'b00};
  assign ic_off_s = ra_s - IC_BASE;
  assign dev_addr = pr_a;
  assign dev_wd   = pr_wd;

  // Window decode; windows are disjoint so at most one select is active.
  always_comb begin
    for (int i = 0; i < N_DEV; i++) begin
      sel_s[i] = (ra_s >= DEV_BASE + 32'(i) * DEV_STRIDE) &&
                 (ra_s <= DEV_BASE + 32'(i) * DEV_STRIDE + DEV_SPAN - 32'd1);
    end
    sel_ic_s = (ra_s >= IC_BASE) && (ra_s <= IC_BASE + 32'd8);
  end

  assign dev_we    = sel_s & {N_DEV{pr_we}};
  assign addr_err  = pr_we & ~(|sel_s) & ~sel_ic_s;
  assign wr_mask_s = pr_we & sel_ic_s & (ic_off_s == 32'd0);
  assign wr_pend_s = pr_we & sel_ic_s & (ic_off_s == 32'd4);
  assign wr_mode_s = pr_we & sel_ic_s & (ic_off_s == 32'd8);

  // Read mux: selected device slice, else IC register, else zero.
  always_comb begin
    pr_rd = 32'd0;
    if (|sel_s) begin
      for (int i = 0; i < N_DEV; i++) begin
        if (sel_s[i]) begin
          pr_rd = dev_rd[32*i +: 32];
        end else begin
          pr_rd = pr_rd;
        end
      end
    end else if (sel_ic_s) begin
      case (ic_off_s)
        32'd0:   pr_rd[N_IRQ-1:0] = mask_q;
        32'd4:   pr_rd[N_IRQ-1:0] = pend_q;
        32'd8:   pr_rd[N_IRQ-1:0] = mode_q;
        default: pr_rd = 32'd0;
      endcase
    end else begin
      pr_rd = 32'd0;
    end
  end

  // Next-state: edge lines hold until W1C, with a new edge beating the clear.
  always_comb begin
    mask_d = wr_mask_s ? pr_wd[N_IRQ-1:0] : mask_q;
    mode_d = wr_mode_s ? pr_wd[N_IRQ-1:0] : mode_q;
    pend_d = pend_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (mode_q[i]) begin
        pend_d[i] = (pend_q[i] & ~(wr_pend_s & pr_wd[i])) | (irq[i] & ~irq_q[i]);
      end else begin
        pend_d[i] = irq[i];
      end
    end
  end

  // IC state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
      irq_q  <= '0;
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      irq_q  <= irq;
    end
  end

  // Interrupt vector: masked pending lines plus raw external line.
  always_comb begin
    hwint             = '0;
    hwint[N_IRQ-1:0]  = pend_q & mask_q;
    hwint[N_IRQ]      = ext_int;
  end

endmodule
